// File: rtl/prog_loader.sv
// Program loader: streams a 16-byte image (plus optional checksum) into a small
// instruction store and releases the CPU from reset once the image is accepted.
module prog_loader #(
   parameter int unsigned CHECKSUM_EN = 1,
   parameter int unsigned TIMEOUT     = 1000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   input  logic       load_req,
   input  logic [3:0] addr,
   output logic [7:0] dout,
   output logic       cpu_run,
   output logic       load_done,
   output logic [1:0] err
);

   localparam int unsigned DW    = 8;
   localparam int unsigned AW    = 4;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned TW    = 24;

   localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT - 1);
   localparam logic [AW-1:0] WPTR_LAST   = AW'(DEPTH - 1);
   localparam logic [1:0]    ERR_NONE    = 2'b00;
   localparam logic [1:0]    ERR_CSUM    = 2'b01;
   localparam logic [1:0]    ERR_TIMEOUT = 2'b10;

   typedef enum logic [1:0] {LOAD, CHECK, RUN, ERR} state_t;

   logic [DW-1:0] mem [DEPTH];

   state_t        state, state_nx;
   logic [AW-1:0] wptr, wptr_nx;
   logic [DW-1:0] sum, sum_nx;
   logic [TW-1:0] tcnt, tcnt_nx;
   logic [1:0]    err_nx;
   logic          cpu_run_nx;
   logic          load_done_nx;
   logic          accept;
   logic          mem_we;
   logic          timing;
   logic [DW-1:0] sum_add;

   assign in_ready = ((state == LOAD) || (state == CHECK)) && !load_req;
   assign accept   = in_valid && in_ready;
   assign dout     = mem[addr];
   assign sum_add  = sum + in_data;
   // An empty image waits forever; only a partial load can time out.
   assign timing   = ((state == LOAD) && (wptr != '0)) || (state == CHECK);

   // Next-state and registered-output logic.
   always_comb begin
      state_nx     = state;
      wptr_nx      = wptr;
      sum_nx       = sum;
      tcnt_nx      = tcnt;
      err_nx       = err;
      load_done_nx = 1'b0;
      mem_we       = 1'b0;

      if (load_req) begin
         state_nx = LOAD;
         wptr_nx  = '0;
         sum_nx   = '0;
         tcnt_nx  = '0;
         err_nx   = ERR_NONE;
      end else if (accept) begin
         tcnt_nx = '0;
         if (state == LOAD) begin
            mem_we  = 1'b1;
            wptr_nx = wptr + AW'(1);
            sum_nx  = sum_add;
            if (wptr == WPTR_LAST) begin
               state_nx = (CHECKSUM_EN != 0) ? CHECK : RUN;
            end
         end else begin
            if (sum_add == '0) begin
               state_nx = RUN;
            end else begin
               state_nx = ERR;
               err_nx   = ERR_CSUM;
            end
         end
      end else if (timing) begin
         if (tcnt == TO_LAST) begin
            state_nx = LOAD;
            wptr_nx  = '0;
            sum_nx   = '0;
            tcnt_nx  = '0;
            err_nx   = ERR_TIMEOUT;
         end else begin
            tcnt_nx = tcnt + TW'(1);
         end
      end

      if ((state_nx == RUN) && (state != RUN)) begin
         load_done_nx = 1'b1;
         err_nx       = ERR_NONE;
      end
      cpu_run_nx = (state_nx == RUN);
   end

   // Control state; cpu_run comes straight from a flop to stay glitch-free.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= LOAD;
         wptr      <= '0;
         sum       <= '0;
         tcnt      <= '0;
         err       <= ERR_NONE;
         cpu_run   <= 1'b0;
         load_done <= 1'b0;
      end else begin
         state     <= state_nx;
         wptr      <= wptr_nx;
         sum       <= sum_nx;
         tcnt      <= tcnt_nx;
         err       <= err_nx;
         cpu_run   <= cpu_run_nx;
         load_done <= load_done_nx;
      end
   end

   // Instruction store has no reset so the image survives load_req and reset.
   always_ff @(posedge clk) begin
      if (reset && mem_we) begin
         mem[wptr] <= in_data;
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed vector table, corner-case
// sequences and randomized traffic checked against an image-queue model.
module tb_prog_loader;

   localparam int unsigned TO = 8;

   logic       clk = 1'b0;
   logic       reset, in_valid, load_req, in_ready, cpu_run, load_done;
   logic [7:0] in_data, dout;
   logic [3:0] addr;
   logic [1:0] err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   prog_loader #(.CHECKSUM_EN(1), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .load_req(load_req), .addr(addr), .dout(dout),
      .cpu_run(cpu_run), .load_done(load_done), .err(err)
   );

   // Reference model: bytes of the image received so far, plus status flags.
   logic [7:0] img_q[$];
   logic [7:0] m_mem[16];
   bit         m_known[16];
   bit         m_run, m_hold, m_done;
   logic [1:0] m_err;
   int         m_idle;

   function automatic bit m_ready(input bit lr);
      return !m_run && !m_hold && !lr;
   endfunction

   function automatic logic [7:0] q_csum();
      logic [7:0] s = 8'h00;
      foreach (img_q[i]) s = s + img_q[i];
      return 8'h00 - s;
   endfunction

   task automatic model_clear();
      img_q.delete();
      m_run  = 1'b0;
      m_hold = 1'b0;
      m_done = 1'b0;
      m_err  = 2'b00;
      m_idle = 0;
   endtask

   task automatic model_step(input bit rst, input bit lr, input bit v, input logic [7:0] d);
      int total;
      if (!rst || lr) begin
         model_clear();
      end else begin
         m_done = 1'b0;
         if (v && m_ready(1'b0)) begin
            m_idle = 0;
            if (img_q.size() < 16) begin
               m_mem[img_q.size()]   = d;
               m_known[img_q.size()] = 1'b1;
               img_q.push_back(d);
            end else begin
               total = int'(d);
               foreach (img_q[i]) total += int'(img_q[i]);
               if (total % 256 == 0) begin
                  m_run  = 1'b1;
                  m_done = 1'b1;
                  m_err  = 2'b00;
               end else begin
                  m_hold = 1'b1;
                  m_err  = 2'b01;
               end
            end
         end else if (img_q.size() > 0 && !m_run && !m_hold) begin
            m_idle++;
            if (m_idle == int'(TO)) begin
               img_q.delete();
               m_idle = 0;
               m_err  = 2'b10;
            end
         end
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: drive inputs, advance the model, compare every output.
   task automatic cycle(input bit rst, input bit lr, input bit v, input logic [7:0] d,
                        input logic [3:0] a);
      reset    = rst;
      load_req = lr;
      in_valid = v;
      in_data  = d;
      addr     = a;
      @(posedge clk);
      model_step(rst, lr, v, d);
      #1;
      check("cpu_run", 32'(cpu_run), 32'(m_run));
      check("load_done", 32'(load_done), 32'(m_done));
      check("err", 32'(err), 32'(m_err));
      check("in_ready", 32'(in_ready), 32'(m_ready(lr)));
      if (m_known[a]) check("dout", 32'(dout), 32'(m_mem[a]));
   endtask

   task automatic idle(input int n, input logic [3:0] a);
      for (int k = 0; k < n; k++) cycle(1'b1, 1'b0, 1'b0, 8'h00, a);
   endtask

   task automatic send_image(input logic [7:0] img[16], input logic [7:0] csum);
      for (int k = 0; k < 16; k++) cycle(1'b1, 1'b0, 1'b1, img[k], 4'(k));
      cycle(1'b1, 1'b0, 1'b1, csum, 4'(0));
   endtask

   typedef struct {
      bit         rst, lr, v;
      logic [7:0] d;
      logic [3:0] a;
      bit         e_run, e_done, e_rdy, chk_dout;
      logic [1:0] e_err;
      logic [7:0] e_dout;
   } vec_t;

   vec_t       tbl[20];
   logic [7:0] img[16];
   logic [7:0] old15;

   initial begin
      reset = 1'b0; load_req = 1'b0; in_valid = 1'b0; in_data = 8'h00; addr = 4'h0;
      model_clear();
      foreach (m_known[i]) m_known[i] = 1'b0;

      // Table: reset 2 cycles, bytes 0x00..0x0F, checksum 0x88, then one idle.
      for (int i = 0; i < 20; i++) begin
         tbl[i] = '{rst: 1'b1, lr: 1'b0, v: 1'b1, d: 8'(i - 2), a: 4'(i - 2),
                    e_run: 1'b0, e_done: 1'b0, e_rdy: 1'b1, chk_dout: 1'b1,
                    e_err: 2'b00, e_dout: 8'(i - 2)};
      end
      tbl[0].rst = 1'b0; tbl[0].v = 1'b0; tbl[0].chk_dout = 1'b0;
      tbl[1].rst = 1'b0; tbl[1].v = 1'b0; tbl[1].chk_dout = 1'b0;
      tbl[18].d = 8'h88; tbl[18].a = 4'h0; tbl[18].e_dout = 8'h00;
      tbl[18].e_run = 1'b1; tbl[18].e_done = 1'b1; tbl[18].e_rdy = 1'b0;
      tbl[19].v = 1'b0; tbl[19].a = 4'h5; tbl[19].e_dout = 8'h05;
      tbl[19].e_run = 1'b1; tbl[19].e_rdy = 1'b0;

      foreach (tbl[i]) begin
         cycle(tbl[i].rst, tbl[i].lr, tbl[i].v, tbl[i].d, tbl[i].a);
         check($sformatf("tbl%0d_run", i), 32'(cpu_run), 32'(tbl[i].e_run));
         check($sformatf("tbl%0d_done", i), 32'(load_done), 32'(tbl[i].e_done));
         check($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].e_err));
         check($sformatf("tbl%0d_rdy", i), 32'(in_ready), 32'(tbl[i].e_rdy));
         if (tbl[i].chk_dout) check($sformatf("tbl%0d_dout", i), 32'(dout), 32'(tbl[i].e_dout));
      end

      // Bad checksum: ERR holds and ignores bytes until load_req.
      cycle(1'b1, 1'b1, 1'b0, 8'h00, 4'h0);
      for (int k = 0; k < 16; k++) img[k] = 8'(k);
      send_image(img, 8'h00);
      check("csum_err", 32'(err), 32'h1);
      check("csum_run", 32'(cpu_run), 32'h0);
      check("csum_rdy", 32'(in_ready), 32'h0);
      cycle(1'b1, 1'b0, 1'b1, 8'h77, 4'h0);
      check("err_hold", 32'(err), 32'h1);
      cycle(1'b1, 1'b1, 1'b0, 8'h00, 4'h0);
      load_req = 1'b0;
      #1;
      check("lr_rdy", 32'(in_ready), 32'h1);
      check("lr_err", 32'(err), 32'h0);

      // Timeout: 3 bytes, then idle exactly TIMEOUT cycles.
      cycle(1'b1, 1'b0, 1'b1, 8'hA1, 4'h0);
      cycle(1'b1, 1'b0, 1'b1, 8'hA2, 4'h0);
      cycle(1'b1, 1'b0, 1'b1, 8'hA3, 4'h0);
      idle(int'(TO) - 1, 4'h0);
      check("to_early", 32'(err), 32'h0);
      idle(1, 4'h0);
      check("to_err", 32'(err), 32'h2);
      cycle(1'b1, 1'b0, 1'b1, 8'h5C, 4'h0);
      check("to_restart", 32'(dout), 32'h5C);
      check("to_err_keep", 32'(err), 32'h2);
      img[0] = 8'h5C;
      for (int k = 1; k < 16; k++) begin
         img[k] = 8'($urandom);
         cycle(1'b1, 1'b0, 1'b1, img[k], 4'(k));
      end
      cycle(1'b1, 1'b0, 1'b1, q_csum(), 4'h0);
      check("to_run", 32'(cpu_run), 32'h1);
      check("to_run_err", 32'(err), 32'h0);

      // load_req in RUN drops cpu_run; old bytes stay until rewritten.
      old15 = img[15];
      cycle(1'b1, 1'b1, 1'b0, 8'h00, 4'hF);
      check("rerun_off", 32'(cpu_run), 32'h0);
      check("rerun_mem", 32'(dout), 32'(old15));
      cycle(1'b1, 1'b0, 1'b1, 8'h11, 4'hF);
      cycle(1'b1, 1'b0, 1'b1, 8'h22, 4'hF);
      check("rerun_mem2", 32'(dout), 32'(old15));

      // load_req with in_valid: byte dropped, pointer back to 0.
      cycle(1'b1, 1'b1, 1'b1, 8'hEE, 4'h0);
      cycle(1'b1, 1'b0, 1'b1, 8'h33, 4'h0);
      check("lrv_wptr0", 32'(dout), 32'h33);

      // Reset mid-load, then a full fresh image.
      for (int k = 0; k < 6; k++) cycle(1'b1, 1'b0, 1'b1, 8'hC0 + 8'(k), 4'h0);
      cycle(1'b0, 1'b0, 1'b1, 8'hDD, 4'h0);
      for (int k = 0; k < 16; k++) img[k] = 8'($urandom);
      img_q.delete();
      foreach (img[k]) img_q.push_back(img[k]);
      old15 = q_csum();
      img_q.delete();
      send_image(img, old15);
      check("rst_run", 32'(cpu_run), 32'h1);
      for (int k = 0; k < 16; k++) begin
         cycle(1'b1, 1'b0, 1'b0, 8'h00, 4'(k));
         check($sformatf("rst_mem%0d", k), 32'(dout), 32'(img[k]));
      end

      // Randomized traffic with idle bursts and occasional load_req/reset.
      for (int n = 0; n < 4000; n++) begin
         int  r;
         bit  rst, lr, v;
         logic [7:0] d;
         r   = int'($urandom_range(0, 299));
         rst = (r != 0);
         lr  = (r == 1) || (r == 2) || (m_run && r < 20);
         v   = ((n % 150) < 138) && ($urandom_range(0, 9) < 7);
         d   = (img_q.size() == 16 && $urandom_range(0, 1) == 1) ? q_csum() : 8'($urandom);
         cycle(rst, lr, v, d, 4'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The block SHALL have parameter CHECKSUM_EN, default 1, which when 1 requires a 17th checksum byte after the 16 program bytes.
REQ-002 The block SHALL have parameter TIMEOUT, default 1000000, giving the number of idle clk cycles that aborts a partial load; legal range 1..2^24-1.
REQ-003 clk  input  1  single clock; all state changes occur on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on rising clk.
REQ-005 in_valid  input  1  upstream byte-valid.
REQ-006 in_data  input  8  upstream program byte.
REQ-007 in_ready  output  1  byte accepted on any cycle with in_valid=1 and in_ready=1.
REQ-008 load_req  input  1  request to (re)start a program load.
REQ-009 addr  input  4  instruction address (CPU program counter).
REQ-010 dout  output  8  instruction byte at addr.
REQ-011 cpu_run  output  1  registered; 0 holds the CPU in reset, 1 lets it run; drives the CPU's active-low reset.
REQ-012 load_done  output  1  one-cycle pulse on successful load completion.
REQ-013 err  output  2  status: 00 none, 01 checksum fail, 10 timeout.

Function
REQ-014 Storage SHALL be 16 x 8 bits; dout SHALL equal mem[addr] combinationally in every state.
REQ-015 States SHALL be LOAD, CHECK, RUN and ERR.
REQ-016 in_ready SHALL be 1 in LOAD and CHECK when load_req=0, and 0 otherwise.
REQ-017 In LOAD, each accepted byte SHALL be written to mem[wptr]; wptr SHALL then increment and sum SHALL become (sum+in_data) mod 256. The write SHALL be visible on dout the following cycle.
REQ-018 Acceptance of the 16th byte (wptr=15) SHALL move the state to CHECK if CHECKSUM_EN=1, or to RUN if CHECKSUM_EN=0; wptr SHALL wrap to 0.
REQ-019 In CHECK, an accepted byte SHALL NOT be written to memory. If (sum+byte) mod 256 = 0, the state SHALL become RUN; otherwise it SHALL become ERR and err SHALL be set to 01.
REQ-020 On entry to RUN, cpu_run SHALL be 1 and load_done SHALL be 1 in the same first RUN cycle; err SHALL be cleared to 00.
REQ-021 cpu_run SHALL be 1 only in RUN.
REQ-022 load_done SHALL be 0 in every cycle except the first RUN cycle.
REQ-023 ERR SHALL hold until load_req or reset; in ERR, in_valid SHALL be ignored.
REQ-024 load_req=1 in any state SHALL cause the following on the next cycle: state LOAD, wptr=0, sum=0, err=00, timeout counter=0, cpu_run=0. Any in_valid in the same cycle SHALL NOT be accepted.
REQ-025 Memory contents SHALL persist across load_req and reset until overwritten.
REQ-026 The timeout counter SHALL increment each cycle in LOAD with wptr!=0, or in CHECK, when no byte is accepted; it SHALL clear on every accept.
REQ-027 When the timeout counter reaches TIMEOUT, the following SHALL happen on the next cycle: state LOAD, wptr=0, sum=0, counter=0, err=10.
REQ-028 err=10 SHALL persist until RUN entry, load_req or reset; a new checksum failure SHALL overwrite it with 01.
REQ-029 In LOAD with wptr=0, the block SHALL wait indefinitely with no timeout.
REQ-030 cpu_run SHALL be driven directly from a flop, with no combinational glitches, because the CPU runs on a divided clock.

Reset
REQ-031 With reset=0 at a rising clk, the following SHALL hold next cycle: state LOAD, wptr=0, sum=0, timeout counter=0, err=00, cpu_run=0, load_done=0, in_ready=1 (if load_req=0). Memory SHALL be unchanged.
REQ-032 Reset SHALL take priority over load_req, in_valid and the timeout.
REQ-033 A reset mid-load SHALL discard progress; the next accepted byte SHALL go to mem[0].

Verification
REQ-034 Reset 2 cycles, then send bytes 0x00..0x0F and checksum 0x88 -> cpu_run=1 and load_done=1 one cycle after the checksum is accepted; load_done=0 the cycle after; addr=5 gives dout=0x05; err=00.
REQ-035 Same 16 bytes, checksum 0x00 -> state ERR, err=01, cpu_run=0, in_ready=0; then load_req pulse -> in_ready=1 and err=00 next cycle.
REQ-036 TIMEOUT=8; send 3 bytes, then idle 8 cycles -> err=10; the next byte lands at mem[0]; a full valid load then gives RUN and err=00.
REQ-037 In RUN, pulse load_req -> cpu_run=0 next cycle; addr=15 still returns the old byte until it is rewritten.
REQ-038 In LOAD, assert load_req and in_valid in the same cycle -> byte not accepted; wptr=0 next cycle.
REQ-039 Reset after 7 bytes, then send a full valid image -> all 16 locations match the new image and cpu_run=1.
